pos_cell_streamer: RTL and testbench
====================================

Name: pos_cell_streamer

Overview:
- Read-side controller placed directly downstream of one per-cell position memory.
- On `start`, reads the particle count from address 0, then streams positions from addresses 1..count to the force-evaluation pipeline using a valid/ready handshake.
- Hides the memory's fixed 2-cycle read latency behind a credit-limited output FIFO, so downstream stalls never drop data.

Parameters:
- DATA_WIDTH, 96, width of one memory word, {posz, posy, posx}.
- ADDR_WIDTH, 8, memory address width.
- PARTICLE_NUM, 220, memory depth; maximum legal count is PARTICLE_NUM-1.
- FIFO_DEPTH, 4, output buffer entries; must be a power of 2 and at least 3.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream the cell; ignored while busy=1.
- mem_address  out  ADDR_WIDTH  address to the cell memory.
- mem_rden  out  1  read enable to the cell memory.
- mem_q  in  DATA_WIDTH  memory read data; valid 2 cycles after the matching mem_rden.
- out_pos  out  DATA_WIDTH  streamed position word.
- out_pid  out  ADDR_WIDTH  memory address of out_pos, in the range 1..count.
- out_valid  out  1  out_pos, out_pid and out_last are valid.
- out_ready  in  1  downstream accepts the word when out_valid and out_ready are both 1.
- out_last  out  1  marks the final particle of the cell.
- count  out  ADDR_WIDTH  latched particle count after clamping.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when streaming completes.
- count_err  out  1  sticky flag: raw count exceeded PARTICLE_NUM-1; cleared by rst or the next accepted start.

Behaviour:
- Reset: every output is 0, the FIFO is empty, the in-flight pipe is cleared and the FSM is IDLE. Reset asserted mid-stream aborts immediately and produces no done pulse.
- States: IDLE -> CNT_REQ -> CNT_WAIT -> STREAM -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1 -> CNT_REQ; busy=1 from the next cycle; count_err cleared.
- CNT_REQ:
  - Drive mem_address=0 and mem_rden=1 for exactly 1 cycle.
  - Go to CNT_WAIT.
- CNT_WAIT:
  - Wait 2 cycles, then latch raw = mem_q[ADDR_WIDTH-1:0].
  - If raw > PARTICLE_NUM-1: count = PARTICLE_NUM-1 and count_err=1.
  - If count==0 -> FIN; no output word is produced.
  - Otherwise -> STREAM with next_addr=1.
- STREAM:
  - Issue a read (mem_rden=1, mem_address=next_addr, then next_addr increments) only when inflight + fifo_occupancy < FIFO_DEPTH.
  - inflight is a 2-bit count of reads issued but not yet returned, tracked by a 2-stage valid/address shift register.
  - After issuing address count -> DRAIN.
- Return path: a returned word is pushed with pid equal to the issued address. The credit rule guarantees a push never meets a full FIFO, so push-on-full is unreachable and an assertion checks it.
- DRAIN: wait until inflight==0 and the FIFO is empty with its last word accepted -> FIN.
- FIN: done=1 and busy=0 for 1 cycle -> IDLE. A start arriving in FIN is ignored.
- Output side:
  - out_valid = FIFO not empty.
  - The head word holds steady while out_ready=0.
  - out_last = (out_pid == count).
  - Simultaneous push and pop in the same cycle keeps occupancy unchanged.
- mem_rden is 0 in every cycle that does not issue a read.
- Throughput: 1 word per cycle when out_ready stays high. The first out_valid appears 3 cycles after the first STREAM read.
- Address arithmetic is unsigned ADDR_WIDTH. next_addr never wraps because count ≤ PARTICLE_NUM-1 < 2^ADDR_WIDTH.

Optional Feature:
- Macro POS_STREAM_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cycles, 16 bits.
  - Counts cycles in STREAM or DRAIN where out_valid=1 and out_ready=0.
  - Saturates at 0xFFFF.
  - Clears on an accepted start and on rst.
- When undefined: the port and its counter are absent and behaviour is otherwise identical.

Test Plan:
- Memory model: 2-cycle latency; addr0=5; addrs 1..5 hold words A..E; out_ready=1; pulse start -> one address-0 read, then out_pid 1,2,3,4,5 on consecutive cycles with A..E, out_last only with pid 5, one done pulse, count=5, count_err=0.
- addr0=0, start -> no out_valid at any time, done pulses, count=0.
- addr0=250 with PARTICLE_NUM=220 -> count=219, count_err=1, exactly 219 words streamed, out_last with pid 219.
- count=10, out_ready toggled in a 1-on/3-off pattern -> all 10 words in order with none lost or duplicated, mem_rden never issues with more than FIFO_DEPTH words outstanding; with POS_STREAM_STALL_CNT_EN defined, stall_cycles equals the observed number of valid-and-not-ready cycles.
- rst asserted on the 4th streamed word -> next cycle every output is 0, FSM is IDLE, no done pulse; a fresh start then streams correctly from pid 1.
- start pulsed again while busy=1 -> ignored; count and the stream are unaffected.

Source files
------------

// File: rtl/pos_cell_streamer_if.sv
// Memory read port and output stream of pos_cell_streamer, grouped for port connection.
interface pos_cell_streamer_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_rden;
   logic [DATA_WIDTH-1:0] mem_q;
   logic [DATA_WIDTH-1:0] out_pos;
   logic [ADDR_WIDTH-1:0] out_pid;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (
      output mem_address, mem_rden, out_pos, out_pid, out_valid, out_last,
      input  mem_q, out_ready
   );

   modport slave (
      input  mem_address, mem_rden, out_pos, out_pid, out_valid, out_last,
      output mem_q, out_ready
   );
endinterface

// File: rtl/pos_cell_streamer.sv
// Streams one cell's particle positions out of a 2-cycle-latency memory through a credit-limited FIFO.
// Optional stall-cycle counter port enabled by defining POS_STREAM_STALL_CNT_EN.
module pos_cell_streamer #(
   parameter int DATA_WIDTH   = 96,
   parameter int ADDR_WIDTH   = 8,
   parameter int PARTICLE_NUM = 220,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   pos_cell_streamer_if.master   bus,
   output logic [ADDR_WIDTH-1:0] count,
   output logic                  busy,
   output logic                  done,
   output logic                  count_err
`ifdef POS_STREAM_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

   typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, FIN} state_t;

   state_t                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]      next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0]      count_q, count_d;
   logic                       err_q, err_d;
   logic                       wait_q, wait_d;
   logic [1:0]                 vld_q;
   logic [1:0][ADDR_WIDTH-1:0] pa_q;
   logic [DATA_WIDTH-1:0]      fpos_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]      fpid_q [FIFO_DEPTH];
   logic [PW-1:0]              wptr_q, rptr_q;
   logic [OW-1:0]              occ_q;
   logic                       rden, issue, push, pop, credit, out_valid;
   logic [ADDR_WIDTH-1:0]      rd_addr, raw;
   logic [OW:0]                credit_sum;

   assign raw        = bus.mem_q[ADDR_WIDTH-1:0];
   // Reads in flight plus words already buffered must leave room for one more issue.
   assign credit_sum = (OW+1)'(occ_q) + (OW+1)'(vld_q[0]) + (OW+1)'(vld_q[1]);
   assign credit     = credit_sum < (OW+1)'(FIFO_DEPTH);
   assign out_valid  = occ_q != '0;
   assign push       = vld_q[1];
   assign pop        = out_valid && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      count_d     = count_q;
      err_d       = err_q;
      wait_d      = 1'b0;
      issue       = 1'b0;
      rden        = 1'b0;
      rd_addr     = '0;
      case (state_q)
         IDLE: if (start) begin
            state_d = CNT_REQ;
            err_d   = 1'b0;
         end
         CNT_REQ: begin
            rden    = 1'b1;
            state_d = CNT_WAIT;
         end
         CNT_WAIT: begin
            wait_d = 1'b1;
            if (wait_q) begin
               wait_d      = 1'b0;
               err_d       = raw > MAX_CNT;
               count_d     = (raw > MAX_CNT) ? MAX_CNT : raw;
               next_addr_d = ADDR_WIDTH'(1);
               state_d     = (count_d == '0) ? FIN : STREAM;
            end
         end
         STREAM: if (credit) begin
            issue       = 1'b1;
            rden        = 1'b1;
            rd_addr     = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            if (next_addr_q == count_q) state_d = DRAIN;
         end
         DRAIN: if (vld_q == '0 && occ_q == '0) state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= IDLE;
         next_addr_q <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         wait_q      <= 1'b0;
         vld_q       <= '0;
         pa_q        <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         count_q     <= count_d;
         err_q       <= err_d;
         wait_q      <= wait_d;
         vld_q       <= {vld_q[0], issue};
         pa_q        <= {pa_q[0], rd_addr};
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         occ_q       <= occ_q + OW'(push) - OW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fpos_q[wptr_q] <= bus.mem_q;
         fpid_q[wptr_q] <= pa_q[1];
      end
      if (!rst && push) assert (occ_q < OW'(FIFO_DEPTH));
   end

`ifdef POS_STREAM_STALL_CNT_EN
   logic [15:0] stall_q;
   always_ff @(posedge clock) begin
      if (rst || (state_q == IDLE && start))
         stall_q <= '0;
      else if ((state_q == STREAM || state_q == DRAIN) && out_valid && !bus.out_ready
               && stall_q != 16'hFFFF)
         stall_q <= stall_q + 1'b1;
   end
   assign stall_cycles = stall_q;
`endif

   assign bus.mem_rden    = rden;
   assign bus.mem_address = rd_addr;
   assign bus.out_valid   = out_valid;
   assign bus.out_pos     = out_valid ? fpos_q[rptr_q] : '0;
   assign bus.out_pid     = out_valid ? fpid_q[rptr_q] : '0;
   assign bus.out_last    = out_valid && (fpid_q[rptr_q] == count_q);
   assign count           = count_q;
   assign count_err       = err_q;
   assign busy            = state_q inside {CNT_REQ, CNT_WAIT, STREAM, DRAIN};
   assign done            = state_q == FIN;
endmodule

// File: tb/tb_pos_cell_streamer.sv
// Randomized bench for pos_cell_streamer: memory model, ready patterns and a queue-based stream reference.
module tb_pos_cell_streamer;
   localparam int DW = 96, AW = 8, PN = 220, FD = 4;

   logic clock = 1'b0, rst = 1'b1, start = 1'b0;
   logic [AW-1:0] count;
   logic busy, done, count_err;
`ifdef POS_STREAM_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   pos_cell_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   pos_cell_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .rst(rst), .start(start), .bus(bus),
      .count(count), .busy(busy), .done(done), .count_err(count_err)
`ifdef POS_STREAM_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   // 2-cycle read latency; junk on the bus whenever no read was issued
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] r1;
   always @(posedge clock) begin
      r1        <= bus.mem_rden ? mem[bus.mem_address] : {3{32'hDEADBEEF}};
      bus.mem_q <= r1;
   end

   int rdy_mode = 0, ph = 0;
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = (ph % 4 == 0);
         default: bus.out_ready = 1'($urandom % 2);
      endcase
      ph++;
   end

   typedef struct { logic [DW-1:0] pos; logic [AW-1:0] pid; logic last; int cyc; } word_t;
   word_t got[$];
   int cyc = 0, cnt_reads, issued, accepted, issue_viol, valid_seen, stall_obs, done_cnt;
   int first_issue, first_valid;

   always @(negedge clock) begin
      cyc++;
      if (!rst) begin
         if (bus.mem_rden && bus.mem_address == 0) cnt_reads++;
         if (bus.mem_rden && bus.mem_address != 0) begin
            if (issued - accepted >= FD) issue_viol++;
            if (issued == 0) first_issue = cyc;
            issued++;
         end
         if (bus.out_valid) begin
            if (valid_seen == 0) first_valid = cyc;
            valid_seen++;
            if (!bus.out_ready) stall_obs++;
         end
         if (bus.out_valid && bus.out_ready) begin
            got.push_back('{bus.out_pos, bus.out_pid, bus.out_last, cyc});
            accepted++;
         end
         if (done) done_cnt++;
      end
   end

   int vec = 0, errs = 0;

   task automatic clear_mon();
      got.delete();
      cnt_reads = 0; issued = 0; accepted = 0; issue_viol = 0;
      valid_seen = 0; stall_obs = 0; done_cnt = 0; first_issue = 0; first_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clock);
      #1 rst = 1'b0;
   endtask

   task automatic start_cell(input int raw);
      for (int a = 1; a < 256; a++) mem[a] = {$urandom, $urandom, $urandom};
      mem[0] = {$urandom, $urandom, $urandom};
      mem[0][7:0] = 8'(raw);
      clear_mon();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   task automatic wait_done(input bit extra, output bit fin);
      fin = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         start = extra && (c == 2 || c == 7 || c == 12);
         if (done_cnt > 0) begin fin = 1'b1; break; end
      end
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
   endtask

   // Reference: words 1..min(raw,PN-1) in address order, last on the final one.
   task automatic check_stream(input string nm, input int raw);
      int n;
      n = (raw > PN - 1) ? PN - 1 : raw;
      vec++;
      if (got.size() !== n) begin
         errs++; $display("FAIL %s words: got %0d, want %0d", nm, got.size(), n);
      end
      for (int i = 0; i < n && i < got.size(); i++) begin
         vec++;
         if (got[i].pos !== mem[i+1] || got[i].pid !== AW'(i+1) || got[i].last !== (i + 1 == n)) begin
            errs++;
            $display("FAIL %s word%0d: got pid=%0d last=%0b pos=%h, want pid=%0d last=%0b pos=%h",
                     nm, i, got[i].pid, got[i].last, got[i].pos, i + 1, (i + 1 == n), mem[i+1]);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      vec++;
      if ({busy, done, count_err, bus.out_valid, bus.out_last, bus.mem_rden} !== 6'b0 ||
          count !== '0 || bus.mem_address !== '0 || bus.out_pid !== '0 || bus.out_pos !== '0) begin
         errs++;
         $display("FAIL reset: busy=%b done=%b err=%b valid=%b last=%b rden=%b count=%0d, want all 0",
                  busy, done, count_err, bus.out_valid, bus.out_last, bus.mem_rden, count);
      end
   endtask

   task automatic test_basic();
      bit fin;
      rdy_mode = 0;
      start_cell(5);
      wait_done(1'b0, fin);
      vec++; if (!fin) begin errs++; $display("FAIL basic timeout: done=%0d, want 1", done_cnt); end
      check_stream("basic", 5);
      vec++; if (done_cnt !== 1) begin errs++; $display("FAIL basic done: got %0d, want 1", done_cnt); end
      vec++; if (count !== 8'd5 || count_err !== 1'b0) begin
         errs++; $display("FAIL basic count: got %0d err=%b, want 5 err=0", count, count_err); end
      vec++; if (cnt_reads !== 1) begin errs++; $display("FAIL basic cnt_reads: got %0d, want 1", cnt_reads); end
      vec++; if (first_valid - first_issue !== 3) begin
         errs++; $display("FAIL basic latency: got %0d, want 3", first_valid - first_issue); end
      for (int i = 1; i < got.size(); i++) begin
         vec++;
         if (got[i].cyc !== got[0].cyc + i) begin
            errs++; $display("FAIL basic rate word%0d: got cycle %0d, want %0d", i, got[i].cyc, got[0].cyc + i);
         end
      end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL basic busy after done: got %b, want 0", busy); end
   endtask

   task automatic test_zero();
      bit fin;
      rdy_mode = 0;
      start_cell(0);
      wait_done(1'b0, fin);
      vec++; if (!fin || done_cnt !== 1) begin errs++; $display("FAIL zero done: got %0d, want 1", done_cnt); end
      vec++; if (valid_seen !== 0) begin errs++; $display("FAIL zero valid cycles: got %0d, want 0", valid_seen); end
      vec++; if (count !== 8'd0) begin errs++; $display("FAIL zero count: got %0d, want 0", count); end
   endtask

   task automatic test_clamp();
      bit fin;
      rdy_mode = 0;
      start_cell(250);
      wait_done(1'b0, fin);
      vec++; if (!fin) begin errs++; $display("FAIL clamp timeout: done=%0d, want 1", done_cnt); end
      vec++; if (count !== 8'(PN - 1) || count_err !== 1'b1) begin
         errs++; $display("FAIL clamp count: got %0d err=%b, want %0d err=1", count, count_err, PN - 1); end
      check_stream("clamp", 250);
   endtask

   task automatic test_backpressure();
      bit fin;
      rdy_mode = 1;
      start_cell(10);
      wait_done(1'b0, fin);
      vec++; if (!fin) begin errs++; $display("FAIL bp timeout: done=%0d, want 1", done_cnt); end
      vec++; if (count_err !== 1'b0) begin errs++; $display("FAIL bp count_err: got %b, want 0", count_err); end
      check_stream("bp", 10);
      vec++; if (issue_viol !== 0) begin errs++; $display("FAIL bp credit: got %0d over-issues, want 0", issue_viol); end
`ifdef POS_STREAM_STALL_CNT_EN
      vec++; if (stall_cycles !== 16'(stall_obs)) begin
         errs++; $display("FAIL bp stall_cycles: got %0d, want %0d", stall_cycles, stall_obs); end
`endif
      rdy_mode = 0;
   endtask

   task automatic test_random();
      bit fin;
      int raw;
      rdy_mode = 2;
      for (int k = 0; k < 3; k++) begin
         raw = $urandom_range(1, 40);
         start_cell(raw);
         wait_done(1'b0, fin);
         vec++; if (!fin || done_cnt !== 1) begin errs++; $display("FAIL rand%0d done: got %0d, want 1", k, done_cnt); end
         check_stream("rand", raw);
         vec++; if (issue_viol !== 0) begin errs++; $display("FAIL rand%0d credit: got %0d, want 0", k, issue_viol); end
`ifdef POS_STREAM_STALL_CNT_EN
         vec++; if (stall_cycles !== 16'(stall_obs)) begin
            errs++; $display("FAIL rand%0d stall_cycles: got %0d, want %0d", k, stall_cycles, stall_obs); end
`endif
      end
      rdy_mode = 0;
   endtask

   task automatic test_abort();
      bit fin, hit;
      rdy_mode = 0;
      hit = 1'b0;
      start_cell(10);
      for (int c = 0; c < 200; c++) begin
         if (bus.out_valid && bus.out_pid == 8'd4) begin hit = 1'b1; break; end
         @(posedge clock); #1;
      end
      vec++; if (!hit) begin errs++; $display("FAIL abort: pid 4 seen=%b, want 1", hit); end
      rst = 1'b1;
      @(posedge clock); #1;
      vec++;
      if ({busy, done, count_err, bus.out_valid, bus.out_last, bus.mem_rden} !== 6'b0 ||
          count !== '0 || bus.out_pid !== '0 || bus.out_pos !== '0 || bus.mem_address !== '0) begin
         errs++; $display("FAIL abort outputs: busy=%b done=%b valid=%b rden=%b count=%0d, want all 0",
                          busy, done, bus.out_valid, bus.mem_rden, count);
      end
      rst = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      vec++; if (done_cnt !== 0 || busy !== 1'b0) begin
         errs++; $display("FAIL abort done: got %0d busy=%b, want 0 busy=0", done_cnt, busy); end
      start_cell(7);
      wait_done(1'b0, fin);
      vec++; if (!fin) begin errs++; $display("FAIL restart timeout: done=%0d, want 1", done_cnt); end
      check_stream("restart", 7);
   endtask

   task automatic test_start_while_busy();
      bit fin;
      rdy_mode = 0;
      start_cell(12);
      wait_done(1'b1, fin);
      vec++; if (!fin || done_cnt !== 1) begin errs++; $display("FAIL busystart done: got %0d, want 1", done_cnt); end
      vec++; if (count !== 8'd12 || cnt_reads !== 1) begin
         errs++; $display("FAIL busystart count: got %0d reads=%0d, want 12 reads=1", count, cnt_reads); end
      check_stream("busystart", 12);
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL busystart idle: busy=%b, want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_clamp();
      test_backpressure();
      test_random();
      test_abort();
      test_start_while_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
